ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Bus arbiter for the multi-master AHB fabric; sits directly upstream of the master-to-slave address/data mux.
- Decides which master owns the address phase. Produces HGRANT, HMASTER, HMASTER_D (the data-phase owner, used for HWDATA muxing) and HMASTLOCK.
- Master index 0 is the default master. It never requests and always drives IDLE. It owns the bus whenever no other master requests.

Parameters:
- NUM_MST, 4, number of masters including default master 0 (range 2..16).
- MW, derived localparam = clog2(NUM_MST), width of the master index.

Ports:
- HCLK  input  1  bus clock; all state changes on the rising edge.
- HRESET  input  1  synchronous reset, active-high.
- HBUSREQ  input  NUM_MST  per-master bus request; bit 0 is ignored.
- HLOCK_M  input  NUM_MST  per-master lock request; bit 0 is ignored.
- HTRANS  input  2  muxed HTRANS from the current address-phase owner.
- HBURST  input  3  muxed HBURST from the current address-phase owner.
- HREADY  input  1  muxed slave ready.
- HGRANT  output  NUM_MST  one-hot grant, registered.
- HMASTER  output  MW  address-phase owner index, registered.
- HMASTER_D  output  MW  data-phase owner index, registered.
- HMASTLOCK  output  1  current address phase is locked, registered.

Behaviour:
- Reset (HRESET=1 at the clock edge): HGRANT=1 (master 0), HMASTER=0, HMASTER_D=0, HMASTLOCK=0, state=ARB, beat counter=0.
- HRESET has priority over every other event, including mid-burst and locked sequences. The arbiter returns to the reset values regardless of bus state.
- Priority: fixed. The lowest requesting index >=1 wins. Master 0 is granted when HBUSREQ[NUM_MST-1:1] is all zero.
- Priority encoding is combinational. HGRANT is registered and updates at the edge after the request is seen (1-cycle request-to-grant latency) when state=ARB.
- HMASTER <= index(HGRANT) only on an edge with HREADY=1. When HREADY=0, HMASTER holds.
- HMASTER_D <= HMASTER on an edge with HREADY=1.
- HMASTLOCK <= HLOCK_M[granted master] on an edge with HREADY=1.
- State ARB:
  - HGRANT follows the priority result every cycle.
  - Go to BURST when all of the following hold at the edge: HREADY=1, HTRANS=NONSEQ, and HBURST in {INCR4, WRAP4, INCR8, WRAP8, INCR16, WRAP16}. Load the beat counter with beats-1 (3/7/15).
  - Go to LOCKED when the HGRANT owner has its HLOCK_M bit set.
  - If both the BURST and LOCKED conditions hold, LOCKED takes precedence. The counter is still loaded.
- State BURST:
  - HGRANT is frozen.
  - Decrement the counter on each edge with HREADY=1 and HTRANS=SEQ. BUSY, or HREADY=0, holds the counter.
  - When the counter reaches 1, return to ARB. Re-arbitration then happens during the final beat's address phase, so the next owner gets its grant aligned with the last beat.
  - HTRANS=IDLE or NONSEQ with HREADY=1 is early termination: clear the counter and go to ARB.
- State LOCKED:
  - HGRANT is frozen while the owner's HLOCK_M bit=1.
  - On deassertion, return to ARB on the next edge with HREADY=1, so one unlocked transfer completes before the handover.
- SINGLE and INCR (undefined length) bursts do not freeze the grant. The arbiter may re-arbitrate on every cycle during them.
- The owner dropping HBUSREQ while in ARB moves the grant to the next requester, or to master 0, one cycle later.
- Simultaneous requests: a strictly lower index wins. No starvation protection is provided; this is a documented limitation.
- HRESP is not used. SPLIT and RETRY are unsupported; slaves must not issue them.

Decomposition:
- Shared `define file (existing AHB defines): HTRANS_IDLE/BUSY/NONSEQ/SEQ and HBURST_SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16 encodings. Add ARB_ST_ARB/BURST/LOCKED state encodings there.
- One sub-module, ahb_prio_enc: combinational fixed-priority encoder, NUM_MST-bit request in, one-hot grant plus MW-bit index out, master 0 as the fallback.

Test Plan:
- Reset then idle: no requests for 10 cycles -> HGRANT=0001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0 throughout.
- Priority: HBUSREQ=0110 asserted at cycle t -> HGRANT=0010 at t+1; HMASTER=1 at the first following edge with HREADY=1.
- Fixed burst hold: master 2 owns the bus and issues INCR4 (NONSEQ+3 SEQ, HREADY=1); master 1 requests during beat 2 -> HGRANT stays 0100 until the last-beat address phase, then changes to 0010.
- Wait states: same INCR4 with HREADY=0 for 2 cycles on beat 3 -> counter and HMASTER hold; handover is delayed by exactly 2 cycles. HMASTER_D lags HMASTER by one HREADY-qualified edge.
- Lock: master 3 with HLOCK_M[3]=1 while master 1 requests -> HGRANT=1000 and HMASTLOCK=1 held. HLOCK_M[3] drops -> grant moves to master 1 after the next HREADY=1 edge.
- Early termination and reset: INCR8 aborted with IDLE after beat 3 -> state ARB and re-arbitration the next cycle. A separate run asserts HRESET mid-INCR16 -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ahb_arbiter_pkg.sv
// rtl/ahb_arbiter_pkg.sv - arbiter types, AHB encodings and burst-length helpers
`include "ahb_defines.svh"

package ahb_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = `HTRANS_IDLE;
    localparam logic [1:0] HTRANS_NONSEQ = `HTRANS_NONSEQ;
    localparam logic [1:0] HTRANS_SEQ    = `HTRANS_SEQ;

    localparam logic [2:0] HBURST_WRAP4  = `HBURST_WRAP4;
    localparam logic [2:0] HBURST_INCR4  = `HBURST_INCR4;
    localparam logic [2:0] HBURST_WRAP8  = `HBURST_WRAP8;
    localparam logic [2:0] HBURST_INCR8  = `HBURST_INCR8;
    localparam logic [2:0] HBURST_WRAP16 = `HBURST_WRAP16;
    localparam logic [2:0] HBURST_INCR16 = `HBURST_INCR16;

    // Beat counter holds (beats - 1), so 4 bits covers a 16-beat burst.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_ARB    = `ARB_ST_ARB,
        ST_BURST  = `ARB_ST_BURST,
        ST_LOCKED = `ARB_ST_LOCKED
    } arb_state_e;

    // Fixed-length bursts are the only ones that freeze the grant.
    function automatic logic is_fixed_burst(input logic [2:0] burst);
        return (burst == HBURST_WRAP4)  || (burst == HBURST_INCR4)  ||
               (burst == HBURST_WRAP8)  || (burst == HBURST_INCR8)  ||
               (burst == HBURST_WRAP16) || (burst == HBURST_INCR16);
    endfunction

    function automatic logic [CNT_W-1:0] burst_beats_m1(input logic [2:0] burst);
        logic [CNT_W-1:0] beats_m1;
        beats_m1 = '0;
        if ((burst == HBURST_WRAP4) || (burst == HBURST_INCR4)) begin
            beats_m1 = 4'd3;
        end else if ((burst == HBURST_WRAP8) || (burst == HBURST_INCR8)) begin
            beats_m1 = 4'd7;
        end else if ((burst == HBURST_WRAP16) || (burst == HBURST_INCR16)) begin
            beats_m1 = 4'd15;
        end
        return beats_m1;
    endfunction

endpackage

// File: rtl/ahb_defines.svh
// rtl/ahb_defines.svh - shared AHB transfer/burst encodings and arbiter state codes
`ifndef AHB_DEFINES_SVH
`define AHB_DEFINES_SVH

`define HTRANS_IDLE    2'b00
`define HTRANS_BUSY    2'b01
`define HTRANS_NONSEQ  2'b10
`define HTRANS_SEQ     2'b11

`define HBURST_SINGLE  3'b000
`define HBURST_INCR    3'b001
`define HBURST_WRAP4   3'b010
`define HBURST_INCR4   3'b011
`define HBURST_WRAP8   3'b100
`define HBURST_INCR8   3'b101
`define HBURST_WRAP16  3'b110
`define HBURST_INCR16  3'b111

`define ARB_ST_ARB     2'd0
`define ARB_ST_BURST   2'd1
`define ARB_ST_LOCKED  2'd2

`endif

// File: rtl/ahb_prio_enc.sv
// rtl/ahb_prio_enc.sv - fixed-priority encoder, lowest requesting index >= 1 wins
//
// Ports:
//   req_i   [NUM_MST-1:0]  request vector; bit 0 ignored (default master)
//   grant_o [NUM_MST-1:0]  one-hot winner, bit 0 when nobody requests
//   idx_o   [MW-1:0]       index of the winner
module ahb_prio_enc
    import ahb_arbiter_pkg::*;
#(
    parameter int NUM_MST = 4,
    parameter int MW      = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req_i,
    output logic [NUM_MST-1:0] grant_o,
    output logic [MW-1:0]      idx_o
);

    // Master 0 is the fallback owner, so its request bit carries no meaning.
    logic unused_req0;
    assign unused_req0 = req_i[0];

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_MST - 1; i >= 1; i--) begin
            if (req_i[i]) begin
                idx_o = MW'(i);
            end
        end
        grant_o        = '0;
        grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB bus arbiter with burst freeze and locked-transfer hold
//
// Ports:
//   HCLK       bus clock, rising edge
//   HRESET     synchronous active-high reset
//   HBUSREQ    per-master bus request (bit 0 ignored)
//   HLOCK_M    per-master lock request (bit 0 ignored)
//   HTRANS     muxed transfer type from the address-phase owner
//   HBURST     muxed burst type from the address-phase owner
//   HREADY     muxed slave ready
//   HGRANT     one-hot grant, registered
//   HMASTER    address-phase owner index, registered
//   HMASTER_D  data-phase owner index, registered
//   HMASTLOCK  current address phase is locked, registered
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter  int NUM_MST = 4,
    localparam int MW      = $clog2(NUM_MST)
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NUM_MST-1:0] HBUSREQ,
    input  logic [NUM_MST-1:0] HLOCK_M,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    output logic [NUM_MST-1:0] HGRANT,
    output logic [MW-1:0]      HMASTER,
    output logic [MW-1:0]      HMASTER_D,
    output logic               HMASTLOCK
);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MST-1:0] hgrant_q, hgrant_d;
    logic [MW-1:0]      gidx_q, gidx_d;     // index of hgrant_q, kept alongside it
    logic [MW-1:0]      hmaster_q;
    logic [MW-1:0]      hmaster_dp_q;       // data-phase owner
    logic               hmastlock_q;

    logic [NUM_MST-1:0] prio_grant;
    logic [MW-1:0]      prio_idx;
    logic               own_lock;
    logic               burst_start;

    ahb_prio_enc #(
        .NUM_MST (NUM_MST),
        .MW      (MW)
    ) u_prio_enc (
        .req_i   (HBUSREQ),
        .grant_o (prio_grant),
        .idx_o   (prio_idx)
    );

    // Master 0 never locks, whatever its HLOCK_M bit says.
    assign own_lock    = (gidx_q != '0) && HLOCK_M[gidx_q];
    assign burst_start = HREADY && (HTRANS == HTRANS_NONSEQ) && is_fixed_burst(HBURST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hgrant_d = hgrant_q;
        gidx_d   = gidx_q;
        case (state_q)
            ST_ARB: begin
                if (burst_start) begin
                    cnt_d = burst_beats_m1(HBURST);
                end
                // A locking owner keeps its grant; otherwise re-arbitrate.
                if (own_lock) begin
                    state_d = ST_LOCKED;
                end else begin
                    hgrant_d = prio_grant;
                    gidx_d   = prio_idx;
                    if (burst_start) begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (HREADY) begin
                    if (HTRANS == HTRANS_SEQ) begin
                        cnt_d = cnt_q - 4'd1;
                        // Leaving at count 1 lets arbitration overlap the final
                        // beat's address phase.
                        if (cnt_q <= 4'd2) begin
                            state_d = ST_ARB;
                        end
                    end else if ((HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ)) begin
                        cnt_d   = '0;
                        state_d = ST_ARB;
                    end
                end
            end
            ST_LOCKED: begin
                // Let one unlocked transfer complete before handing over.
                if (!own_lock && HREADY) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ST_ARB;
            cnt_q        <= '0;
            hgrant_q     <= NUM_MST'(1);
            gidx_q       <= '0;
            hmaster_q    <= '0;
            hmaster_dp_q <= '0;
            hmastlock_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hgrant_q <= hgrant_d;
            gidx_q   <= gidx_d;
            if (HREADY) begin
                hmaster_q    <= gidx_q;
                hmaster_dp_q <= hmaster_q;
                hmastlock_q  <= own_lock;
            end
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_dp_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - self-checking bench for ahb_arbiter
module tb_ahb_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [2:0] B_INCR16 = 3'b111;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK_M;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HREADY;
    logic [N-1:0] HGRANT;
    logic [W-1:0] HMASTER;
    logic [W-1:0] HMASTER_D;
    logic         HMASTLOCK;

    ahb_arbiter #(.NUM_MST(N)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK_M   (HLOCK_M),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    // Model: who holds the grant and why it is (or is not) pinned there.
    localparam int FREE = 0, HELD_BY_BURST = 1, HELD_BY_LOCK = 2;
    int m_grant    = 0;
    int m_master   = 0;
    int m_master_d = 0;
    int m_lock     = 0;
    int m_why      = FREE;
    int m_left     = 0;   // SEQ beats still owed by the current fixed burst

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input int act, input int mdl, input int exp);
        chk(name, act, exp);
        chk({name, "_model"}, mdl, exp);
    endtask

    task automatic model_step();
        int  lowest;
        int  new_grant;
        int  new_why;
        bit  owner_locks;
        bit  fixed_start;
        if (HRESET) begin
            m_grant = 0; m_master = 0; m_master_d = 0; m_lock = 0;
            m_why = FREE; m_left = 0;
        end else begin
            lowest = 0;
            for (int i = 1; i < N; i++) begin
                if (HBUSREQ[i] && lowest == 0) lowest = i;
            end
            owner_locks = (m_grant != 0) && (HLOCK_M[m_grant] == 1'b1);
            fixed_start = HREADY && (HTRANS == T_NSEQ) && (int'(HBURST) >= 2);
            new_grant = m_grant;
            new_why   = m_why;
            if (m_why == FREE) begin
                // beats = 4, 8, 16 for burst codes {2,3}, {4,5}, {6,7}
                if (fixed_start) m_left = (1 << ((int'(HBURST) >> 1) + 1)) - 1;
                if (owner_locks) begin
                    new_why = HELD_BY_LOCK;
                end else begin
                    new_grant = lowest;
                    if (fixed_start) new_why = HELD_BY_BURST;
                end
            end else if (m_why == HELD_BY_BURST) begin
                if (HREADY && HTRANS == T_SEQ) begin
                    m_left = m_left - 1;
                    if (m_left <= 1) new_why = FREE;
                end else if (HREADY && (HTRANS == T_IDLE || HTRANS == T_NSEQ)) begin
                    m_left  = 0;
                    new_why = FREE;
                end
            end else begin
                if (!owner_locks && HREADY) new_why = FREE;
            end
            if (HREADY) begin
                m_master_d = m_master;
                m_master   = m_grant;
                m_lock     = owner_locks ? 1 : 0;
            end
            m_grant = new_grant;
            m_why   = new_why;
        end
    endtask

    // One bus cycle: drive, advance the model, clock, then compare every output.
    task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy, input logic rst);
        HBUSREQ = req; HLOCK_M = lck; HTRANS = tr; HBURST = bu;
        HREADY = rdy; HRESET = rst;
        model_step();
        @(posedge HCLK);
        #1;
        chk("hgrant",    int'(HGRANT),    1 << m_grant);
        chk("hmaster",   int'(HMASTER),   m_master);
        chk("hmaster_d", int'(HMASTER_D), m_master_d);
        chk("hmastlock", int'(HMASTLOCK), m_lock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    endtask

    task automatic own(input logic [N-1:0] req);
        cyc(req, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        cyc(req, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    endtask

    initial begin
        HBUSREQ = '0; HLOCK_M = '0; HTRANS = T_IDLE; HBURST = B_SINGLE;
        HREADY = 1'b1; HRESET = 1'b1;

        // Reset, then idle
        cyc(4'b0110, 4'b1000, T_IDLE, B_SINGLE, 1'b1, 1'b1);
        cyc(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b1);
        pin("rst_hgrant", int'(HGRANT), 1 << m_grant, 1);
        pin("rst_hmaster", int'(HMASTER), m_master, 0);
        pin("rst_hmastlock", int'(HMASTLOCK), m_lock, 0);
        idle(10);
        pin("idle_hgrant", int'(HGRANT), 1 << m_grant, 4'b0001);

        // Priority: masters 1 and 2 request, 1 wins
        cyc(4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        pin("prio_hgrant", int'(HGRANT), 1 << m_grant, 4'b0010);
        pin("prio_hmaster_pre", int'(HMASTER), m_master, 0);
        cyc(4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1'b0, 1'b0);
        pin("prio_hmaster_wait", int'(HMASTER), m_master, 0);
        cyc(4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        pin("prio_hmaster", int'(HMASTER), m_master, 1);
        cyc(4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        pin("prio_hmaster_d", int'(HMASTER_D), m_master_d, 1);
        idle(3);

        // INCR4 by master 2 with master 1 arriving on beat 2
        own(4'b0100);
        pin("burst_owner", int'(HMASTER), m_master, 2);
        cyc(4'b0100, 4'b0000, T_NSEQ, B_INCR4, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR4, 1'b1, 1'b0);
        pin("burst_frozen1", int'(HGRANT), 1 << m_grant, 4'b0100);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR4, 1'b1, 1'b0);
        pin("burst_frozen2", int'(HGRANT), 1 << m_grant, 4'b0100);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR4, 1'b1, 1'b0);
        pin("burst_handover", int'(HGRANT), 1 << m_grant, 4'b0010);
        pin("burst_hmaster_last", int'(HMASTER), m_master, 2);
        cyc(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        pin("burst_hmaster_new", int'(HMASTER), m_master, 1);
        idle(3);

        // Same INCR4 with two wait states on beat 3
        own(4'b0100);
        cyc(4'b0100, 4'b0000, T_NSEQ, B_INCR4, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR4, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR4, 1'b0, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR4, 1'b0, 1'b0);
        pin("wait_frozen", int'(HGRANT), 1 << m_grant, 4'b0100);
        pin("wait_hmaster", int'(HMASTER), m_master, 2);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR4, 1'b1, 1'b0);
        pin("wait_frozen_after", int'(HGRANT), 1 << m_grant, 4'b0100);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR4, 1'b1, 1'b0);
        pin("wait_handover", int'(HGRANT), 1 << m_grant, 4'b0010);
        cyc(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        pin("wait_hmaster_new", int'(HMASTER), m_master, 1);
        pin("wait_hmaster_d", int'(HMASTER_D), m_master_d, 2);
        idle(3);

        // Locked master 3 while master 1 requests
        cyc(4'b1000, 4'b1000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        cyc(4'b1010, 4'b1000, T_NSEQ, B_INCR4,  1'b1, 1'b0);
        cyc(4'b1010, 4'b1000, T_SEQ,  B_INCR4,  1'b1, 1'b0);
        cyc(4'b1010, 4'b1000, T_NSEQ, B_SINGLE, 1'b1, 1'b0);
        cyc(4'b1010, 4'b1000, T_BUSY, B_SINGLE, 1'b1, 1'b0);
        pin("lock_hgrant", int'(HGRANT), 1 << m_grant, 4'b1000);
        pin("lock_hmastlock", int'(HMASTLOCK), m_lock, 1);
        cyc(4'b1010, 4'b0000, T_NSEQ, B_SINGLE, 1'b0, 1'b0);
        pin("lock_drop_wait", int'(HGRANT), 1 << m_grant, 4'b1000);
        pin("lock_drop_wait_ml", int'(HMASTLOCK), m_lock, 1);
        cyc(4'b1010, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 1'b0);
        pin("lock_last_xfer", int'(HGRANT), 1 << m_grant, 4'b1000);
        cyc(4'b1010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        pin("lock_handover", int'(HGRANT), 1 << m_grant, 4'b0010);
        idle(3);

        // Undefined-length INCR does not freeze the grant
        own(4'b0100);
        cyc(4'b0100, 4'b0000, T_NSEQ, B_INCR, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR, 1'b1, 1'b0);
        pin("incr_rearb", int'(HGRANT), 1 << m_grant, 4'b0010);
        idle(3);

        // INCR8 by master 1 aborted with IDLE after beat 3, BUSY holds count
        own(4'b0010);
        cyc(4'b0010, 4'b0000, T_NSEQ, B_INCR8, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR8, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_BUSY, B_INCR8, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR8, 1'b1, 1'b0);
        cyc(4'b0100, 4'b0000, T_IDLE, B_INCR8, 1'b1, 1'b0);
        pin("abort_frozen", int'(HGRANT), 1 << m_grant, 4'b0010);
        cyc(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 1'b0);
        pin("abort_rearb", int'(HGRANT), 1 << m_grant, 4'b0100);
        idle(3);

        // Reset in the middle of an INCR16
        own(4'b0100);
        cyc(4'b0100, 4'b0000, T_NSEQ, B_INCR16, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR16, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR16, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, T_SEQ,  B_INCR16, 1'b1, 1'b1);
        pin("mrst_hgrant", int'(HGRANT), 1 << m_grant, 4'b0001);
        pin("mrst_hmaster", int'(HMASTER), m_master, 0);
        pin("mrst_hmaster_d", int'(HMASTER_D), m_master_d, 0);
        cyc(4'b0010, 4'b0000, T_SEQ,  B_INCR16, 1'b1, 1'b0);
        pin("mrst_arb", int'(HGRANT), 1 << m_grant, 4'b0010);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
